// File: rtl/gpio_irq_pkg.sv
// Shared constants for the GPIO edge-interrupt stage: bus addresses,
// byte-lane positions of the CONFIG/STATUS fields and debounce sizing.
package gpio_irq_pkg;

    localparam int CNT_W = 8;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_CONFIG = 1'b1;

    // CONFIG lanes; the IFR write-1-to-clear byte lives in STATUS lane 2
    localparam int LANE_IER   = 0;
    localparam int LANE_RISE  = 1;
    localparam int LANE_FALL  = 2;
    localparam int LANE_DBCNT = 3;
    localparam int LANE_IFR   = 2;

    localparam logic [CNT_W-1:0] DBCNT_RST = CNT_W'(3);

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic [7:0] laneByte(input logic [31:0] word, input int lane);
        return word[8*lane +: 8];
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One port bit: two-flop synchroniser followed by a counting debouncer that
// only accepts a new level after it has been held for dbcnt+1 cycles.
module gpio_debounce_bit
    import gpio_irq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pin,
    input  logic [CNT_W-1:0] dbcnt,
    output logic             sync,
    output logic             db
);

    logic s1_q;
    logic sync_q;
    logic db_q, db_d;
    cnt_t cnt_q, cnt_d;

    // ">=" rather than "==" so that lowering the threshold below the running
    // count still accepts the change on the next compare instead of wrapping.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (sync_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q >= dbcnt) begin
            db_d  = sync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b0;
            sync_q <= 1'b0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= pin;
            sync_q <= s1_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync = sync_q;
    assign db   = db_q;

endmodule

// File: rtl/gpio_edge_irq.sv
// GPIO input conditioning and edge interrupt block: per-bit debounce, sticky
// edge flags with write-1-to-clear, config registers and a level irq line.
module gpio_edge_irq
    import gpio_irq_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             address,
    input  logic [3:0]       byte_en,
    input  logic [31:0]      data,
    input  logic             rw,
    input  logic             clken,
    input  logic [WIDTH-1:0] pin_in,
    output logic [31:0]      q,
    output logic             irq
);

    logic [WIDTH-1:0] syncVec;
    logic [WIDTH-1:0] dbVec;
    logic [WIDTH-1:0] dbPrev_q;
    logic [WIDTH-1:0] ifr_q, ifr_d;
    logic [WIDTH-1:0] ier_q, ier_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    cnt_t             dbcnt_q, dbcnt_d;
    logic [31:0]      q_q, q_d;
    logic             irq_q, irq_d;

    logic             cfgWr;
    logic             statWr;
    logic [WIDTH-1:0] edgeSet;
    logic [WIDTH-1:0] ifrClr;
    logic [31:0]      readWord;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_debounce_bit u_debounce (
            .clk   (clk),
            .reset (reset),
            .pin   (pin_in[i]),
            .dbcnt (dbcnt_q),
            .sync  (syncVec[i]),
            .db    (dbVec[i])
        );
    end

    assign cfgWr  = clken && !rw && (address == ADDR_CONFIG);
    assign statWr = clken && !rw && (address == ADDR_STATUS);

    assign edgeSet = (dbVec & ~dbPrev_q & rise_q) | (~dbVec & dbPrev_q & fall_q);
    assign ifrClr  = (statWr && byte_en[LANE_IFR]) ? laneByte(data, LANE_IFR) : '0;

    assign readWord = (address == ADDR_STATUS) ? {8'h00, ifr_q, dbVec, syncVec}
                                               : {dbcnt_q, fall_q, rise_q, ier_q};

    // Clear is applied before set so a coincident edge keeps its flag.
    always_comb begin
        ier_d   = ier_q;
        rise_d  = rise_q;
        fall_d  = fall_q;
        dbcnt_d = dbcnt_q;
        if (cfgWr) begin
            if (byte_en[LANE_IER])   ier_d   = laneByte(data, LANE_IER);
            if (byte_en[LANE_RISE])  rise_d  = laneByte(data, LANE_RISE);
            if (byte_en[LANE_FALL])  fall_d  = laneByte(data, LANE_FALL);
            if (byte_en[LANE_DBCNT]) dbcnt_d = laneByte(data, LANE_DBCNT);
        end
        ifr_d = (ifr_q & ~ifrClr) | edgeSet;
        q_d   = (clken && rw) ? readWord : q_q;
        irq_d = |(ifr_q & ier_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbPrev_q <= '0;
            ifr_q    <= '0;
            ier_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            dbcnt_q  <= DBCNT_RST;
            q_q      <= '0;
            irq_q    <= 1'b0;
        end else begin
            dbPrev_q <= dbVec;
            ifr_q    <= ifr_d;
            ier_q    <= ier_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            dbcnt_q  <= dbcnt_d;
            q_q      <= q_d;
            irq_q    <= irq_d;
        end
    end

    assign q   = q_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Directed bench for gpio_edge_irq: expected register images and irq timing
// are worked out by hand for each vector.
module tb_gpio_edge_irq;

    logic        clk;
    logic        reset;
    logic        address;
    logic [3:0]  byte_en;
    logic [31:0] data;
    logic        rw;
    logic        clken;
    logic [7:0]  pin_in;
    logic [31:0] q;
    logic        irq;

    int assertCount = 0;
    int failCount   = 0;

    gpio_edge_irq #(.WIDTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .byte_en (byte_en),
        .data    (data),
        .rw      (rw),
        .clken   (clken),
        .pin_in  (pin_in),
        .q       (q),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pins);
        pin_in = pins;
    endtask

    task automatic busWrite(input logic a, input logic [3:0] be, input logic [31:0] d);
        address = a;
        byte_en = be;
        data    = d;
        rw      = 1'b0;
        clken   = 1'b1;
        tick();
        clken   = 1'b0;
        rw      = 1'b1;
        byte_en = 4'b0000;
        data    = 32'h0;
    endtask

    task automatic readCheck(input logic a, input string tag, input logic [31:0] expected);
        address = a;
        rw      = 1'b1;
        clken   = 1'b1;
        tick();
        clken   = 1'b0;
        checkOutput(tag, q, expected);
    endtask

    initial begin
        reset   = 1'b1;
        address = 1'b0;
        byte_en = 4'b0000;
        data    = 32'h0;
        rw      = 1'b1;
        clken   = 1'b0;
        pin_in  = 8'h00;
        tick(3);
        checkOutput("reset_irq", {31'h0, irq}, 32'h0);
        checkOutput("reset_q", q, 32'h0);
        reset = 1'b0;

        readCheck(1'b1, "default_config", 32'h03000000);
        readCheck(1'b0, "default_status", 32'h00000000);
        checkOutput("default_irq", {31'h0, irq}, 32'h0);

        // Rising edge on bit 2: irq exactly 8 cycles after the pin change
        busWrite(1'b1, 4'b0011, 32'h00000404);
        readCheck(1'b1, "cfg_rise2", 32'h03000404);
        applyStimulus(8'h04);
        tick(7);
        checkOutput("rise2_irq_early", {31'h0, irq}, 32'h0);
        tick();
        checkOutput("rise2_irq_on_time", {31'h0, irq}, 32'h1);
        readCheck(1'b0, "rise2_status", 32'h00040404);
        busWrite(1'b0, 4'b0100, 32'h00040000);
        checkOutput("rise2_irq_after_clr", {31'h0, irq}, 32'h1);
        tick();
        checkOutput("rise2_irq_cleared", {31'h0, irq}, 32'h0);

        // Glitch rejection on bit 5
        busWrite(1'b1, 4'b0011, 32'h00002424);
        applyStimulus(8'h24);
        tick(3);
        applyStimulus(8'h04);
        tick(12);
        checkOutput("glitch3_irq", {31'h0, irq}, 32'h0);
        readCheck(1'b0, "glitch3_status", 32'h00000404);
        applyStimulus(8'h24);
        tick(6);
        applyStimulus(8'h04);
        tick(15);
        checkOutput("pulse6_irq", {31'h0, irq}, 32'h1);
        readCheck(1'b0, "pulse6_status", 32'h00200404);
        busWrite(1'b0, 4'b0100, 32'h00200000);
        tick();
        checkOutput("pulse6_irq_cleared", {31'h0, irq}, 32'h0);

        // Falling edge on bit 0 and lane-gated W1C
        busWrite(1'b1, 4'b0111, 32'h00012425);
        applyStimulus(8'h05);
        tick(10);
        readCheck(1'b0, "bit0_high_status", 32'h00000505);
        checkOutput("bit0_high_irq", {31'h0, irq}, 32'h0);
        applyStimulus(8'h04);
        tick(10);
        readCheck(1'b0, "fall0_status", 32'h00010404);
        checkOutput("fall0_irq", {31'h0, irq}, 32'h1);
        busWrite(1'b0, 4'b0001, 32'h00010000);
        tick(2);
        readCheck(1'b0, "w1c_wrong_lane", 32'h00010404);
        busWrite(1'b0, 4'b0100, 32'h00010000);
        checkOutput("fall0_irq_hold", {31'h0, irq}, 32'h1);
        tick();
        checkOutput("fall0_irq_cleared", {31'h0, irq}, 32'h0);
        readCheck(1'b0, "fall0_cleared_status", 32'h00000404);

        // Set beats clear: W1C lands on the edge that sets IFR[3]
        busWrite(1'b1, 4'b0011, 32'h00002C2D);
        applyStimulus(8'h0C);
        tick(6);
        busWrite(1'b0, 4'b0100, 32'h00080000);
        readCheck(1'b0, "set_beats_clear", 32'h00080C0C);
        checkOutput("set_beats_clear_irq", {31'h0, irq}, 32'h1);
        busWrite(1'b0, 4'b0100, 32'h00080000);
        tick(2);
        readCheck(1'b0, "bit3_cleared", 32'h00000C0C);

        // DBCNT=0 accepts a single-cycle mismatch
        busWrite(1'b1, 4'b1011, 32'h00006C6D);
        readCheck(1'b1, "cfg_dbcnt0", 32'h00016C6D);
        applyStimulus(8'h4C);
        tick();
        applyStimulus(8'h0C);
        tick(6);
        readCheck(1'b0, "dbcnt0_status", 32'h00400C0C);
        checkOutput("dbcnt0_irq", {31'h0, irq}, 32'h1);

        // Reset in the middle of a long debounce count
        busWrite(1'b1, 4'b1000, 32'hC8000000);
        applyStimulus(8'h8C);
        tick(100);
        checkOutput("pre_reset_irq", {31'h0, irq}, 32'h1);
        reset = 1'b1;
        tick(2);
        checkOutput("midcount_reset_irq", {31'h0, irq}, 32'h0);
        checkOutput("midcount_reset_q", q, 32'h0);
        reset = 1'b0;
        busWrite(1'b1, 4'b0011, 32'h00008080);
        readCheck(1'b1, "post_reset_config", 32'h03008080);
        readCheck(1'b0, "post_reset_status", 32'h0000008C);
        tick(4);
        checkOutput("post_reset_irq_early", {31'h0, irq}, 32'h0);
        tick();
        checkOutput("post_reset_irq_on_time", {31'h0, irq}, 32'h1);
        readCheck(1'b0, "post_reset_final", 32'h00808C8C);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
